bits_gather: RTL

Serial-to-symbol packer on the PSK receive path, the inverse of the transmit-side bit flattener. It collects a demodulated bit stream, one bit per valid cycle, into N-bit symbols, first bit in the LSB. In BPSK mode (`bypass` high) it emits one symbol per bit. Completed symbols pass through a small output FIFO with a ready/valid handshake toward the frame/byte logic downstream.

---
 rtl/psk_pkg.sv | 23 ++
 rtl/sym_fifo.sv | 95 +++++++++
 rtl/bits_gather.sv | 123 ++++++++++++
 3 files changed

// File: rtl/psk_pkg.sv
// ---------------------------------------------------------------------------
// psk_pkg
// Constants shared by the PSK transmit-side bit flattener and the receive-side
// bits_gather packer, so both ends agree on symbol geometry.
//   QPSK_BITS      : bits per symbol in QPSK mode
//   SYM_W          : width of a symbol word on the byte/frame side
//   BPSK_BIT_SEL   : symbol bit that carries the data bit in BPSK mode
//   SYM_FIFO_DEPTH : entries in the receive symbol FIFO
// ---------------------------------------------------------------------------
package psk_pkg;

  localparam int QPSK_BITS      = 2;
  localparam int SYM_W          = 8;
  localparam int BPSK_BIT_SEL   = 1;
  localparam int SYM_FIFO_DEPTH = 4;

  // Width of a counter that runs 0..n-1. The result is never smaller than
  // one bit, so n == 1 still produces a legal vector.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sym_fifo.sv
// ---------------------------------------------------------------------------
// sym_fifo
// Synchronous FIFO with a registered output word. The head entry is always
// presented on rd_data/rd_vld from a register, so nothing passes
// combinationally from the write side to the read side. A word written into
// an empty FIFO is visible on the following cycle.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   wr_en       : push request
//   wr_data     : word to push
//   rd_en       : downstream ready; a pop happens when rd_en & rd_vld
//   rd_data     : head word (0 while empty)
//   rd_vld      : FIFO holds at least one word
//   full        : all entries occupied
// A push while full is ignored unless a pop happens in the same cycle.
// ---------------------------------------------------------------------------
module sym_fifo
  import psk_pkg::*;
#(
  parameter int W     = SYM_W,
  parameter int DEPTH = SYM_FIFO_DEPTH
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         wr_en,
  input  logic [W-1:0] wr_data,
  input  logic         rd_en,
  output logic [W-1:0] rd_data,
  output logic         rd_vld,
  output logic         full
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW:0]   wr_ptr_reg, wr_ptr_next;
  logic [AW:0]   rd_ptr_reg, rd_ptr_next;
  logic [W-1:0]  rd_data_reg;
  logic          rd_vld_reg;
  logic          empty;
  logic          do_push, do_pop;
  logic [W-1:0]  head_next;

  // Pointers carry one extra MSB: equal pointers mean empty, equal index with
  // differing MSB means full.
  assign empty = (wr_ptr_reg == rd_ptr_reg);
  assign full  = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                 (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);

  assign do_pop  = rd_en & ~empty;
  assign do_push = wr_en & (~full | do_pop);

  always_comb begin
    wr_ptr_next = wr_ptr_reg + (AW+1)'(do_push);
    rd_ptr_next = rd_ptr_reg + (AW+1)'(do_pop);
    // The next head is normally read from storage; when it is the very slot
    // being written this cycle the storage still holds stale data, so the
    // incoming word is taken instead.
    if (do_push && (rd_ptr_next[AW-1:0] == wr_ptr_reg[AW-1:0])) begin
      head_next = wr_data;
    end else begin
      head_next = mem[rd_ptr_next[AW-1:0]];
    end
  end

  // Storage carries no reset so it can map onto RAM.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr_reg[AW-1:0]] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg  <= '0;
      rd_ptr_reg  <= '0;
      rd_data_reg <= '0;
      rd_vld_reg  <= 1'b0;
    end else begin
      wr_ptr_reg <= wr_ptr_next;
      rd_ptr_reg <= rd_ptr_next;
      if (wr_ptr_next == rd_ptr_next) begin
        rd_data_reg <= '0;
        rd_vld_reg  <= 1'b0;
      end else begin
        rd_data_reg <= head_next;
        rd_vld_reg  <= 1'b1;
      end
    end
  end

  assign rd_data = rd_data_reg;
  assign rd_vld  = rd_vld_reg;

endmodule

// File: rtl/bits_gather.sv
// ---------------------------------------------------------------------------
// bits_gather
// Receive-side serial-to-symbol packer. Demodulated bits arrive one per valid
// cycle and are packed LSB-first into N-bit symbols (QPSK), or emitted one
// bit per symbol at bit BYPASS_SELECTION (BPSK, bypass high). Finished
// symbols are queued in sym_fifo and handed downstream with ready/valid.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   bypass     : BPSK mode, sampled with I_vld
//   I, I_vld   : serial bit and its qualifier
//   I_sof      : start of frame; the qualified bit is bit 0 of a new symbol
//   O, O_vld   : assembled symbol (upper M-N bits zero) and valid
//   O_rdy      : downstream ready
//   drop       : one-cycle pulse, a partial symbol was discarded
//   overflow   : one-cycle pulse, a finished symbol was lost to a full FIFO
// ---------------------------------------------------------------------------
module bits_gather
  import psk_pkg::*;
#(
  parameter int N                = QPSK_BITS,
  parameter int M                = SYM_W,
  parameter int BYPASS_SELECTION = BPSK_BIT_SEL,
  parameter int FIFO_DEPTH       = SYM_FIFO_DEPTH
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         bypass,
  input  logic         I,
  input  logic         I_vld,
  input  logic         I_sof,
  output logic [M-1:0] O,
  output logic         O_vld,
  input  logic         O_rdy,
  output logic         drop,
  output logic         overflow
);

  localparam int CNT_WIDTH = cnt_width(N);
  localparam logic [CNT_WIDTH-1:0] LAST = CNT_WIDTH'(N-1);

  logic [CNT_WIDTH-1:0] cnt_reg, cnt_next;
  logic [N-1:0]         acc_reg, acc_next;
  logic                 drop_reg, drop_next;
  logic                 overflow_reg, overflow_next;
  logic                 push;
  logic [M-1:0]         push_data;
  logic [CNT_WIDTH-1:0] idx;
  logic [N-1:0]         sym;
  logic                 fifo_full;

  always_comb begin
    cnt_next  = cnt_reg;
    acc_next  = acc_reg;
    drop_next = 1'b0;
    push      = 1'b0;
    push_data = '0;
    idx       = cnt_reg;
    sym       = acc_reg;
    if (I_vld) begin
      if (bypass) begin
        // Switching to BPSK mid-symbol throws the partial symbol away.
        drop_next = (cnt_reg != '0);
        cnt_next  = '0;
        acc_next  = '0;
        push      = 1'b1;
        push_data[BYPASS_SELECTION] = I;
      end else begin
        // SOF mid-symbol realigns: this bit becomes bit 0 of a fresh symbol.
        if (I_sof && (cnt_reg != '0)) begin
          drop_next = 1'b1;
          idx       = '0;
          sym       = '0;
        end
        sym[idx] = I;
        if (idx == LAST) begin
          push             = 1'b1;
          push_data[N-1:0] = sym;
          cnt_next         = '0;
          acc_next         = '0;
        end else begin
          acc_next = sym;
          cnt_next = idx + CNT_WIDTH'(1);
        end
      end
    end
  end

  // A pop in the same cycle frees a slot, so only push-while-full-without-pop
  // loses the symbol.
  assign overflow_next = push & fifo_full & ~(O_vld & O_rdy);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg      <= '0;
      acc_reg      <= '0;
      drop_reg     <= 1'b0;
      overflow_reg <= 1'b0;
    end else begin
      cnt_reg      <= cnt_next;
      acc_reg      <= acc_next;
      drop_reg     <= drop_next;
      overflow_reg <= overflow_next;
    end
  end

  sym_fifo #(
    .W     (M),
    .DEPTH (FIFO_DEPTH)
  ) u_sym_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (push),
    .wr_data (push_data),
    .rd_en   (O_rdy),
    .rd_data (O),
    .rd_vld  (O_vld),
    .full    (fifo_full)
  );

  assign drop     = drop_reg;
  assign overflow = overflow_reg;

endmodule
